// File: rtl/address_sequencer_pkg.sv
// Shared command encoding for the address sequencer.
// Imported by the top level and by the bench.
package address_sequencer_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_HOLD = 3'b000;
  localparam logic [CMD_W-1:0] CMD_LOAD = 3'b001;
  localparam logic [CMD_W-1:0] CMD_INC  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_CALL = 3'b011;
  localparam logic [CMD_W-1:0] CMD_RET  = 3'b100;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for the sequencer.
// Push when full and pop when empty are dropped.
module return_stack #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_WIDTH-1:0]              push_data,
  output logic [ADDR_WIDTH-1:0]              top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int DW = $clog2(STACK_DEPTH+1);

  logic [ADDR_WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [DW-1:0]         r_depth;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_top;

  assign full   = (r_depth == DW'(STACK_DEPTH));
  assign empty  = (r_depth == '0);
  assign depth  = r_depth;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty & ~push;
  assign top    = w_top;

  // Select the newest valid entry; zero when empty.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) begin
        w_top = r_mem[i];
      end
    end
  end

  // Write the pushed address into the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (r_depth == DW'(i)) begin
          r_mem[i] <= push_data;
        end
      end
    end
  end

  // Track the number of valid entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= '0;
    end else if (w_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

endmodule

// File: rtl/address_sequencer.sv
// Address / PC source: hold, load, increment, call, return.
// Return addresses live in a LIFO; misuse sets sticky flags.
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    STACK_DEPTH = 4,
  parameter int                    INC_STEP    = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CMD_W-1:0]                   cmd,
  input  logic [ADDR_WIDTH-1:0]              data_in,
  input  logic                               clr_err,
  output logic [ADDR_WIDTH-1:0]              addr_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_is_load;
  logic                  w_is_inc;
  logic                  w_is_call;
  logic                  w_is_ret;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [ADDR_WIDTH-1:0] w_top;

  // Decode the command; unused codes behave as HOLD.
  always_comb begin
    w_is_load = 1'b0;
    w_is_inc  = 1'b0;
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    case (cmd)
      CMD_LOAD: w_is_load = 1'b1;
      CMD_INC:  w_is_inc  = 1'b1;
      CMD_CALL: w_is_call = 1'b1;
      CMD_RET:  w_is_ret  = 1'b1;
      default:  ;
    endcase
  end

  // Carry out of the top bit is dropped so the address wraps.
  assign w_next = r_addr + ADDR_WIDTH'(INC_STEP);
  assign w_push = w_is_call & ~w_full;
  assign w_pop  = w_is_ret & ~w_empty;

  return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_next),
    .top       (w_top),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Update the current address for the accepted command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= RESET_ADDR;
    end else if (w_is_load || w_push) begin
      r_addr <= data_in;
    end else if (w_is_inc) begin
      r_addr <= w_next;
    end else if (w_pop) begin
      r_addr <= w_top;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (w_is_call & w_full) | (r_ovf & ~clr_err);
      r_unf <= (w_is_ret & w_empty) | (r_unf & ~clr_err);
    end
  end

  assign addr_out    = r_addr;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Parametrised successor to the single load-only address register. It holds the current address, and supports hold, load, increment with wrap-around, and call/return through an internal LIFO of return addresses. Overflow and underflow of the LIFO are flagged. It sits between the control unit and memory as the processor's address/PC source. `addr_out` drives the memory address bus directly.

## Interface
- ADDR_WIDTH, 8, width of the address and of every stack entry
- STACK_DEPTH, 4, number of return-address entries (≥2, power of two not required)
- INC_STEP, 1, amount added on INC and used to form the return address on CALL
- RESET_ADDR, 0, value loaded into `addr_out` on reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd  in  3  operation code: 000 HOLD, 001 LOAD, 010 INC, 011 CALL, 100 RET, 101–111 treated as HOLD
- data_in  in  ADDR_WIDTH  target address for LOAD and CALL
- clr_err  in  1  clears the sticky error flags
- addr_out  out  ADDR_WIDTH  current address (registered)
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  out  1  depth == STACK_DEPTH (combinational from depth)
- stack_empty  out  1  depth == 0 (combinational from depth)
- ovf_err  out  1  sticky: CALL attempted while full
- unf_err  out  1  sticky: RET attempted while empty

## Operation
- Reset (rst=0, asynchronous) sets the following:
  - addr_out=RESET_ADDR, depth=0
  - all stack entries=0
  - ovf_err=0, unf_err=0
  - stack_empty=1, stack_full=0
- HOLD: no state change.
- LOAD: addr_out←data_in.
- INC: addr_out←(addr_out+INC_STEP) mod 2^ADDR_WIDTH. The carry is discarded and there is no flag.
- CALL when not full:
  - stack[depth]←(addr_out+INC_STEP) mod 2^ADDR_WIDTH
  - depth←depth+1
  - addr_out←data_in
- CALL when full: addr_out, depth and stack are unchanged; ovf_err←1.
- RET when not empty: addr_out←stack[depth-1]; depth←depth-1. The popped entry's contents are don't-care afterward.
- RET when empty: addr_out and depth are unchanged; unf_err←1.
- Error flags:
  - clr_err=1 clears both flags in the cycle it is sampled.
  - If the same cycle raises an error, the set wins: the flag is 1 afterward.
- Stack behaviour:
  - The stack is strict LIFO; no wrap-around of the stack pointer.
  - Overflowing calls are dropped, never overwrite.

## Timing
- Every command takes effect at the first rising clk edge at which it is sampled. addr_out, depth and the flags reflect it immediately after that edge, i.e. one-cycle latency, with registered outputs.
- Back-to-back commands are permitted every cycle. CALL then RET on consecutive cycles returns to the CALL address + INC_STEP.
- stack_full and stack_empty track depth within the same cycle, with no extra latency.
- Reset deasserted mid-sequence restarts from the reset state. Reset asserted asynchronously at any point forces the reset values without waiting for clk.
- data_in is sampled only for LOAD and CALL; it is ignored otherwise.

## Structure
- A shared package `address_sequencer_pkg` holds:
  - the cmd encoding localparams: CMD_HOLD, CMD_LOAD, CMD_INC, CMD_CALL, CMD_RET
  - the cmd width constant (3)
- Sub-module `return_stack` provides:
  - a parametrised LIFO (ADDR_WIDTH, STACK_DEPTH) with push and pop inputs
  - push_data input, top output, depth, full and empty outputs
  - the same clk and rst
  - push-when-full and pop-when-empty ignored internally
- The top level decodes cmd, updates addr_out, generates push/pop, and owns the sticky error flags.

## Test plan
All scenarios use ADDR_WIDTH=8, STACK_DEPTH=4, INC_STEP=1, RESET_ADDR=0.
1. Reset then LOAD 8'hF0, INC ×16 → addr_out sequence F0…FF, then 00. The wrap is silent and no error flags are set.
2. LOAD 8'h10, CALL 8'h40, INC, INC, RET → addr_out=8'h11, depth returns 0, stack_empty=1.
3. Four nested CALLs (targets 20, 30, 40, 50) from addr 05 → stack_full=1, depth=4. A fifth CALL 8'h60 leaves addr_out=50 and sets ovf_err=1. Four RETs then yield 41, 31, 21, 06.
4. Perform a RET with stack empty → addr_out unchanged and unf_err=1. Next cycle, clr_err=1 with HOLD → unf_err=0. Then clr_err=1 together with RET on empty → unf_err stays 1.
5. Assert rst low asynchronously between clock edges with depth=2, addr_out=8'h33 → outputs are immediately addr_out=0, depth=0, flags 0. The first CALL after release pushes 8'h01.
6. Drive illegal cmd 3'b101–111 with random data_in → no change to any output.
